dma_sd_wr: RTL and testbench

SD-card write DMA controller: the transmit-direction companion of the SD read DMA. It fetches one 512-byte block from RAM through the DMA sequencer and streams it to the SD-card SPI byte engine as a data packet: gap, start token 0xFE, 512 data bytes and CRC16. It then checks the card's data-response token, waits out card busy, and raises an interrupt. It sits beside the read DMA on the same ports.v register window, the same SPI engine and the same DMA sequencer channel type.

---
 rtl/dma_sd_wr_pkg.sv | 50 +++++
 rtl/sd_crc16.sv | 40 ++++
 rtl/dma_sd_wr.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_dma_sd_wr.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_sd_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_sd_wr_pkg
//  Description : Shared definitions for the SD-card write DMA: FSM state
//                encoding, register selects, packet constants and the
//                byte-serial CRC16-CCITT step function.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package dma_sd_wr_pkg;

  // Each state names the byte currently in flight on the SPI engine.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_GAP   = 4'd1,
    ST_TOKEN = 4'd2,
    ST_DATA  = 4'd3,
    ST_CRCH  = 4'd4,
    ST_CRCL  = 4'd5,
    ST_RESP  = 4'd6,
    ST_BUSY  = 4'd7,
    ST_STOP  = 4'd8
  } state_e;

  localparam logic [1:0] SEL_HAD = 2'b00;
  localparam logic [1:0] SEL_MAD = 2'b01;
  localparam logic [1:0] SEL_LAD = 2'b10;
  localparam logic [1:0] SEL_CST = 2'b11;

  localparam logic [7:0]  IDLE_BYTE  = 8'hFF;
  localparam logic [7:0]  DATA_TOKEN = 8'hFE;
  localparam logic [4:0]  RESP_MASK  = 5'b11111;
  localparam logic [4:0]  RESP_OK    = 5'b00101;
  localparam logic [9:0]  BLOCK_LEN  = 10'd512;
  localparam logic [15:0] CRC_POLY   = 16'h1021;

  // One byte of CRC16-CCITT, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc16.sv
`default_nettype none
// ============================================================================
//  Module      : sd_crc16
//  Description : Byte-serial CRC16-CCITT (poly 0x1021, init 0x0000, MSB
//                first). Usable for both SD write and read data paths.
//  Ports       : clk_i, rst_i  clock / async active-high reset
//                clr_i         synchronous clear to 0x0000 (wins over en_i)
//                en_i          fold data_i into the CRC this cycle
//                data_i [7:0]  byte to fold in
//                crc_o [15:0]  running CRC value
//  Revision    : 1.0  initial release
// ============================================================================
module sd_crc16
  import dma_sd_wr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)     crc_d = 16'h0000;
    else if (en_i) crc_d = crc16_byte(crc_q, data_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) crc_q <= 16'h0000;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/dma_sd_wr.sv
`default_nettype none
// ============================================================================
//  Module      : dma_sd_wr
//  Description : SD-card write DMA. Fetches a 512-byte block from RAM via the
//                DMA sequencer and sends it to the SPI byte engine as a data
//                packet (gap, 0xFE, data, CRC16), checks the data-response
//                token, waits out card busy and pulses int_req.
//  Ports       : clk_i, rst_i              clock / async active-high reset
//                sd_start_o, sd_senddata_o  SPI byte request and byte
//                sd_rdy_i, sd_recvdata_i    SPI idle flag and received byte
//                din_i, dout_o, module_select_i, write_strobe_i, regsel_i
//                                           register window
//                dma_addr_o, dma_rd_i, dma_rnw_o, dma_req_o, dma_ack_i,
//                dma_end_i                  DMA sequencer channel (read only)
//                int_req_o                  one-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module dma_sd_wr
  import dma_sd_wr_pkg::*;
#(
  parameter int RESP_POLLS = 8
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        sd_start_o,
  output logic [7:0]  sd_senddata_o,
  input  logic        sd_rdy_i,
  input  logic [7:0]  sd_recvdata_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  dout_o,
  input  logic        module_select_i,
  input  logic        write_strobe_i,
  input  logic [1:0]  regsel_i,
  output logic [21:0] dma_addr_o,
  input  logic [7:0]  dma_rd_i,
  output logic        dma_rnw_o,
  output logic        dma_req_o,
  input  logic        dma_ack_i,
  input  logic        dma_end_i,
  output logic        int_req_o
);

  localparam int PW = $clog2(RESP_POLLS + 1);

  state_e          state_q, state_d;
  logic            dma_on_q, dma_on_d;
  logic            err_q, err_d;
  logic [21:0]     addr_q, addr_d;
  logic            dma_req_q, dma_req_d;
  logic            outst_q, outst_d;
  logic [7:0]      buf_q, buf_d;
  logic            buf_vld_q, buf_vld_d;
  logic [9:0]      req_cnt_q, req_cnt_d;
  logic [8:0]      byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic            sd_start_q, sd_start_d;
  logic [7:0]      send_q, send_d;
  logic            int_req_q, int_req_d;

  logic            w_wr, w_ack, w_rdy, w_set_err, w_consume, w_crc_en;
  logic [15:0]     w_crc;

  assign w_wr  = module_select_i && write_strobe_i;
  assign w_ack = dma_req_q && dma_ack_i;
  // The engine keeps sd_rdy high during the sd_start cycle, so a byte just
  // launched must not be mistaken for a finished one.
  assign w_rdy = sd_rdy_i && !sd_start_q;

  // ---------------- register window ----------------
  always_comb begin
    addr_d   = addr_q;
    dma_on_d = dma_on_q;
    err_d    = err_q;
    // A sequencer handshake beats a concurrent address register write.
    if (dma_on_q && w_ack) begin
      addr_d = addr_q + 22'd1;
    end else if (w_wr) begin
      case (regsel_i)
        SEL_HAD: addr_d[21:16] = din_i[5:0];
        SEL_MAD: addr_d[15:8]  = din_i;
        SEL_LAD: addr_d[7:0]   = din_i;
        default: ;
      endcase
    end
    if (w_wr && regsel_i == SEL_CST) begin
      dma_on_d = din_i[7];
      if (din_i[7]) err_d = 1'b0;
    end
    if (w_set_err) err_d = 1'b1;
    if (state_q == ST_STOP) dma_on_d = 1'b0;
  end

  always_comb begin
    case (regsel_i)
      SEL_HAD: dout_o = {2'b00, addr_q[21:16]};
      SEL_MAD: dout_o = addr_q[15:8];
      SEL_LAD: dout_o = addr_q[7:0];
      default: dout_o = {dma_on_q, err_q, 6'b0};
    endcase
  end

  // ---------------- prefetch pipeline ----------------
  always_comb begin
    outst_d   = outst_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    req_cnt_d = req_cnt_q;
    if (!dma_on_q) begin
      // Stale dma_end after an abort finds outst_q clear and is dropped.
      outst_d   = 1'b0;
      buf_vld_d = 1'b0;
      req_cnt_d = 10'd0;
    end else begin
      if (w_ack) begin
        outst_d   = 1'b1;
        req_cnt_d = req_cnt_q + 10'd1;
      end else if (outst_q && dma_end_i) begin
        outst_d   = 1'b0;
        buf_d     = dma_rd_i;
        buf_vld_d = 1'b1;
      end
      if (w_consume) buf_vld_d = 1'b0;
    end
    // Only one byte of storage: a new fetch starts once the buffer has been
    // handed to the SPI engine, so it overlaps that byte's transmission.
    // dma_on_d drops the request on the same edge as an abort write.
    dma_req_d = dma_on_q && dma_on_d && (req_cnt_d < BLOCK_LEN)
                && !outst_d && !buf_vld_d;
  end

  // ---------------- packet FSM ----------------
  always_comb begin
    state_d    = state_q;
    sd_start_d = 1'b0;
    send_d     = send_q;
    byte_cnt_d = byte_cnt_q;
    poll_d     = poll_q;
    w_set_err  = 1'b0;
    w_consume  = 1'b0;
    w_crc_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        byte_cnt_d = 9'd0;
        poll_d     = '0;
        if (dma_on_q && w_rdy) begin
          sd_start_d = 1'b1;
          send_d     = IDLE_BYTE;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_rdy) begin
          sd_start_d = 1'b1;
          send_d     = DATA_TOKEN;
          state_d    = ST_TOKEN;
        end
      end
      ST_TOKEN, ST_DATA: begin
        if (w_rdy) begin
          // byte_cnt has wrapped to 0 after the 512th data byte.
          if (state_q == ST_DATA && byte_cnt_q == 9'd0) begin
            sd_start_d = 1'b1;
            send_d     = w_crc[15:8];
            state_d    = ST_CRCH;
          end else if (buf_vld_q) begin
            sd_start_d = 1'b1;
            send_d     = buf_q;
            w_consume  = 1'b1;
            w_crc_en   = 1'b1;
            byte_cnt_d = byte_cnt_q + 9'd1;
            state_d    = ST_DATA;
          end
        end
      end
      ST_CRCH: begin
        if (w_rdy) begin
          sd_start_d = 1'b1;
          send_d     = w_crc[7:0];
          state_d    = ST_CRCL;
        end
      end
      ST_CRCL: begin
        if (w_rdy) begin
          sd_start_d = 1'b1;
          send_d     = IDLE_BYTE;
          poll_d     = PW'(1);
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_rdy) begin
          if ((sd_recvdata_i[4:0] & RESP_MASK) == RESP_OK) begin
            sd_start_d = 1'b1;
            send_d     = IDLE_BYTE;
            state_d    = ST_BUSY;
          end else if (sd_recvdata_i == IDLE_BYTE && poll_q < PW'(RESP_POLLS)) begin
            sd_start_d = 1'b1;
            send_d     = IDLE_BYTE;
            poll_d     = poll_q + PW'(1);
          end else begin
            w_set_err = 1'b1;
            state_d   = ST_STOP;
          end
        end
      end
      ST_BUSY: begin
        if (w_rdy) begin
          if (sd_recvdata_i == IDLE_BYTE) begin
            state_d = ST_STOP;
          end else begin
            sd_start_d = 1'b1;
            send_d     = IDLE_BYTE;
          end
        end
      end
      ST_STOP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!dma_on_q) begin
      state_d    = ST_IDLE;
      sd_start_d = 1'b0;
      send_d     = send_q;
      byte_cnt_d = 9'd0;
      poll_d     = '0;
      w_set_err  = 1'b0;
      w_consume  = 1'b0;
      w_crc_en   = 1'b0;
    end
    // Gated by dma_on so an abort landing on STOP stays silent.
    int_req_d = (state_q == ST_STOP) && dma_on_q;
  end

  sd_crc16 u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!dma_on_q),
    .en_i   (w_crc_en),
    .data_i (buf_q),
    .crc_o  (w_crc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      dma_on_q   <= 1'b0;
      err_q      <= 1'b0;
      dma_req_q  <= 1'b0;
      outst_q    <= 1'b0;
      buf_q      <= 8'h00;
      buf_vld_q  <= 1'b0;
      req_cnt_q  <= 10'd0;
      byte_cnt_q <= 9'd0;
      poll_q     <= '0;
      sd_start_q <= 1'b0;
      send_q     <= IDLE_BYTE;
      int_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dma_on_q   <= dma_on_d;
      err_q      <= err_d;
      dma_req_q  <= dma_req_d;
      outst_q    <= outst_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      req_cnt_q  <= req_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      poll_q     <= poll_d;
      sd_start_q <= sd_start_d;
      send_q     <= send_d;
      int_req_q  <= int_req_d;
    end
  end

  // The RAM address is software state and survives reset.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
  end

  assign sd_start_o    = sd_start_q;
  assign sd_senddata_o = send_q;
  assign dma_addr_o    = addr_q;
  assign dma_rnw_o     = 1'b1;
  assign dma_req_o     = dma_req_q;
  assign int_req_o     = int_req_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_sd_wr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_sd_wr
//  Description : Directed self-checking bench for dma_sd_wr with an SPI byte
//                engine model, a DMA sequencer model and a scripted card.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_sd_wr;

  localparam int SPI_LAT = 6;
  localparam int DMA_LAT = 2;
  localparam int LIMIT   = 12000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sd_start;
  logic [7:0]  sd_senddata;
  logic        sd_rdy = 1'b1;
  logic [7:0]  sd_recvdata = 8'hFF;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        module_select = 1'b0;
  logic        write_strobe = 1'b0;
  logic [1:0]  regsel = 2'b00;
  logic [21:0] dma_addr;
  logic [7:0]  dma_rd = 8'h00;
  logic        dma_rnw;
  logic        dma_req;
  logic        dma_ack = 1'b0;
  logic        dma_end = 1'b0;
  logic        int_req;

  int          vec = 0;
  int          miss = 0;
  logic [7:0]  tx [0:1023];
  int          tx_n = 0;
  logic [7:0]  rq [$];
  logic [7:0]  resp_default = 8'hFF;
  logic [7:0]  fill = 8'h00;
  int          int_cnt = 0;
  int          spi_cnt = 0;
  logic [7:0]  cur_resp = 8'hFF;
  int          dma_cnt = 0;
  logic        dma_busy = 1'b0;

  dma_sd_wr #(.RESP_POLLS(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sd_start_o      (sd_start),
    .sd_senddata_o   (sd_senddata),
    .sd_rdy_i        (sd_rdy),
    .sd_recvdata_i   (sd_recvdata),
    .din_i           (din),
    .dout_o          (dout),
    .module_select_i (module_select),
    .write_strobe_i  (write_strobe),
    .regsel_i        (regsel),
    .dma_addr_o      (dma_addr),
    .dma_rd_i        (dma_rd),
    .dma_rnw_o       (dma_rnw),
    .dma_req_o       (dma_req),
    .dma_ack_i       (dma_ack),
    .dma_end_i       (dma_end),
    .int_req_o       (int_req)
  );

  always #5 clk = ~clk;

  // SPI engine + card: exchanges from index 516 on are the response phase.
  always @(negedge clk) begin
    if (!sd_rdy) begin
      if (spi_cnt == 0) begin
        sd_rdy      = 1'b1;
        sd_recvdata = cur_resp;
      end else begin
        spi_cnt = spi_cnt - 1;
      end
    end else if (sd_start) begin
      if (tx_n < 1024) tx[tx_n] = sd_senddata;
      if (tx_n >= 516) cur_resp = (rq.size() > 0) ? rq.pop_front() : resp_default;
      else             cur_resp = 8'hFF;
      tx_n    = tx_n + 1;
      sd_rdy  = 1'b0;
      spi_cnt = SPI_LAT;
    end
  end

  // DMA sequencer: one-cycle ack, data DMA_LAT+1 cycles later.
  always @(negedge clk) begin
    if (dma_ack) begin
      dma_ack = 1'b0;
      dma_cnt = DMA_LAT;
    end else if (dma_end) begin
      dma_end  = 1'b0;
      dma_busy = 1'b0;
    end else if (dma_busy) begin
      if (dma_cnt == 0) begin
        dma_end = 1'b1;
        dma_rd  = fill;
      end else begin
        dma_cnt = dma_cnt - 1;
      end
    end else if (dma_req) begin
      dma_ack  = 1'b1;
      dma_busy = 1'b1;
    end
  end

  always @(negedge clk) if (int_req) int_cnt = int_cnt + 1;

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    module_select = 1'b1; write_strobe = 1'b1; regsel = sel; din = d;
    @(posedge clk); #1;
    module_select = 1'b0; write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [7:0] d);
    regsel = sel; #1; d = dout;
  endtask

  task automatic start_run(input logic [7:0] f);
    fill = f; tx_n = 0; int_cnt = 0;
    wr(2'b11, 8'h80);
  endtask

  task automatic wait_int(input string name);
    int n = 0;
    while (int_cnt == 0 && n < LIMIT) begin @(posedge clk); n++; end
    vec++;
    if (int_cnt == 0) begin
      miss++;
      $display("FAIL %s_timeout: no int_req after %0d cycles, tx count %0d", name, n, tx_n);
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_n < n && k < LIMIT) begin @(posedge clk); k++; end
    vec++;
    if (tx_n < n) begin
      miss++;
      $display("FAIL wait_tx: tx count %0d, required %0d", tx_n, n);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [7:0] f);
    int bad = 0;
    for (int i = 2; i < 514; i++) if (tx[i] !== f) bad++;
    chk_int(name, bad, 0);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (dma_req !== 1'b0 || sd_start !== 1'b0 || int_req !== 1'b0 || dma_rnw !== 1'b1) begin
      miss++;
      $display("FAIL reset_ctl: req=%b start=%b int=%b rnw=%b, expected 0 0 0 1",
               dma_req, sd_start, int_req, dma_rnw);
    end
    chk8("reset_senddata", sd_senddata, 8'hFF);
    rd(2'b11, v); chk8("reset_cst", v, 8'h00);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    wr(2'b00, 8'hC1); wr(2'b01, 8'h23); wr(2'b10, 8'h45);
    rd(2'b00, v); chk8("had_rb", v, 8'h01);
    rd(2'b01, v); chk8("mad_rb", v, 8'h23);
    rd(2'b10, v); chk8("lad_rb", v, 8'h45);
  endtask

  task automatic test_zero_block();
    logic [7:0] v;
    rq = {8'hE5}; resp_default = 8'hFF;
    start_run(8'h00);
    vec++;
    if (dma_req !== 1'b0 || sd_start !== 1'b0) begin
      miss++;
      $display("FAIL start_t0: req=%b start=%b, expected 0 0", dma_req, sd_start);
    end
    @(posedge clk); #1;
    vec++;
    if (dma_req !== 1'b1 || sd_start !== 1'b1) begin
      miss++;
      $display("FAIL start_t1: req=%b start=%b, expected 1 1", dma_req, sd_start);
    end
    rd(2'b11, v); chk8("cst_running", v, 8'h80);
    wait_int("zero");
    chk_int("zero_txn", tx_n, 518);
    chk8("zero_gap", tx[0], 8'hFF);
    chk8("zero_token", tx[1], 8'hFE);
    check_data("zero_data", 8'h00);
    chk8("zero_crch", tx[514], 8'h00);
    chk8("zero_crcl", tx[515], 8'h00);
    chk8("zero_poll", tx[516], 8'hFF);
    chk8("zero_busy", tx[517], 8'hFF);
    chk_int("zero_int", int_cnt, 1);
    rd(2'b11, v); chk8("zero_cst", v, 8'h00);
    rd(2'b00, v); chk8("zero_had", v, 8'h01);
    rd(2'b01, v); chk8("zero_mad", v, 8'h25);
    rd(2'b10, v); chk8("zero_lad", v, 8'h45);
  endtask

  task automatic test_ff_block();
    rq = {8'h05}; resp_default = 8'hFF;
    start_run(8'hFF);
    wait_int("ff");
    chk_int("ff_txn", tx_n, 518);
    check_data("ff_data", 8'hFF);
    chk8("ff_crch", tx[514], 8'h7F);
    chk8("ff_crcl", tx[515], 8'hA1);
  endtask

  task automatic test_crc_err();
    logic [7:0] v;
    rq = {8'h0B}; resp_default = 8'hFF;
    start_run(8'h00);
    wait_int("crcerr");
    chk_int("crcerr_txn", tx_n, 517);
    chk_int("crcerr_int", int_cnt, 1);
    rd(2'b11, v); chk8("crcerr_cst", v, 8'h40);
  endtask

  task automatic test_resp_timeout();
    logic [7:0] v;
    rq = {}; resp_default = 8'hFF;
    start_run(8'h00);
    rd(2'b11, v); chk8("start_clears_err", v, 8'h80);
    wait_int("timeout");
    chk_int("timeout_txn", tx_n, 524);
    chk_int("timeout_int", int_cnt, 1);
    rd(2'b11, v); chk8("timeout_cst", v, 8'h40);
  endtask

  task automatic test_busy();
    logic [7:0] v;
    rq = {8'hE5, 8'h00, 8'h00, 8'h00}; resp_default = 8'hFF;
    start_run(8'h00);
    wait_int("busy");
    chk_int("busy_exchanges", tx_n - 517, 4);
    chk_int("busy_int", int_cnt, 1);
    rd(2'b11, v); chk8("busy_cst", v, 8'h00);
  endtask

  task automatic test_abort();
    logic [7:0] v;
    int snap;
    rq = {8'hE5}; resp_default = 8'hFF;
    start_run(8'h00);
    wait_tx(202);
    wr(2'b11, 8'h00);
    @(posedge clk); #1;
    chk_int("abort_req", int'(dma_req), 0);
    snap = tx_n;
    repeat (150) @(posedge clk);
    #1;
    chk_int("abort_no_start", tx_n, snap);
    chk_int("abort_no_int", int_cnt, 0);
    rd(2'b11, v); chk8("abort_cst", v, 8'h00);
    rq = {8'hE5};
    start_run(8'hFF);
    wait_int("restart1");
    chk_int("restart1_txn", tx_n, 518);
    check_data("restart1_data", 8'hFF);
    chk8("restart1_crch", tx[514], 8'h7F);
    chk8("restart1_crcl", tx[515], 8'hA1);
  endtask

  task automatic test_rst_busy();
    logic [7:0] v;
    int snap;
    rq = {8'hE5}; resp_default = 8'h00;
    start_run(8'h00);
    wait_tx(520);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vec++;
    if (dma_req !== 1'b0 || sd_start !== 1'b0 || int_req !== 1'b0) begin
      miss++;
      $display("FAIL rst_busy_ctl: req=%b start=%b int=%b, expected 0 0 0",
               dma_req, sd_start, int_req);
    end
    rd(2'b11, v); chk8("rst_busy_cst", v, 8'h00);
    snap = tx_n;
    repeat (150) @(posedge clk);
    #1;
    chk_int("rst_no_start", tx_n, snap);
    chk_int("rst_no_int", int_cnt, 0);
    resp_default = 8'hFF;
    rq = {8'hE5};
    start_run(8'h00);
    wait_int("restart2");
    chk_int("restart2_txn", tx_n, 518);
    chk8("restart2_token", tx[1], 8'hFE);
    check_data("restart2_data", 8'h00);
    chk_int("restart2_int", int_cnt, 1);
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_ff_block();
    test_crc_err();
    test_resp_timeout();
    test_busy();
    test_abort();
    test_rst_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
